gated_pipe_reg: RTL

- Parametrised elastic pipeline of STAGES registers, each WIDTH bits wide, with a valid/ready handshake.
- Input data is ANDed bit-wise with a per-bit mask on entry; output data is forced to zero whenever the output is not valid.
- Registers masked or qualified datapath values, such as immediate or ALU-result gating, between datapath sections when moving the single-cycle MIPS toward pipelined operation.
- Generalises the single-bit AND gating to a per-bit mask, adds storage, backpressure and flush.

---
 rtl/gated_pipe_reg_pkg.sv | 13 +
 rtl/gated_pipe_reg_stage.sv | 44 ++++
 rtl/gated_pipe_reg.sv | 86 ++++++++
 3 files changed

// File: rtl/gated_pipe_reg_pkg.sv
// gated_pipe_reg_pkg: shared defaults and helpers for the gated elastic pipeline.
//   WIDTH_DEF / STAGES_DEF : default data width and stage count.
//   occ_width(stages)      : bits needed to count 0..stages occupied stages.
package gated_pipe_reg_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 2;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/gated_pipe_reg_stage.sv
// gated_pipe_reg_stage: one valid/data register of the elastic pipeline.
//   clk, rst_n        : clock, asynchronous active-low reset.
//   flush             : synchronous clear of the valid bit (dominates load).
//   load              : this stage's ready; when high the stage takes its input.
//   in_valid, in_data : word offered by the previous stage (or the entry gate).
//   out_valid, out_data : registered stage contents.
module gated_pipe_stage
    import gated_pipe_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Data only moves with a real word, so bubbles never overwrite held data.
    always_comb begin
        valid_d = flush ? 1'b0 : (load ? in_valid : valid_q);
        data_d  = (load && in_valid) ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/gated_pipe_reg.sv
// gated_pipe_reg: elastic valid/ready pipeline of STAGES registers with per-bit
// entry mask and zero-gated output.
//   clk, rst_n           : clock, asynchronous active-low reset.
//   flush                : clears all stage valids at the next edge.
//   in_valid/in_ready    : upstream handshake; in_data & in_mask is stored.
//   out_valid/out_ready  : downstream handshake; out_data is zero when not valid.
//   occupancy            : count of valid stages, present only when the
//                          GATED_PIPE_OCC_EN macro is defined.
module gated_pipe_reg
    import gated_pipe_reg_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef GATED_PIPE_OCC_EN
    output logic [occ_width(STAGES)-1:0] occupancy,
`endif
    output logic [WIDTH-1:0] out_data
);

    // rdy[k] is stage k's ready; rdy[STAGES] is the downstream ready.
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vprev;
    logic [WIDTH-1:0]  dat   [STAGES];
    logic [WIDTH-1:0]  dprev [STAGES];

    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            assign vprev[k] = in_valid;
            assign dprev[k] = in_data & in_mask;
        end else begin : g_chain
            assign vprev[k] = vld[k-1];
            assign dprev[k] = dat[k-1];
        end
        assign rdy[k] = rdy[k+1] | ~vld[k];
        gated_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .load      (rdy[k]),
            .in_valid  (vprev[k]),
            .in_data   (dprev[k]),
            .out_valid (vld[k]),
            .out_data  (dat[k])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1] & {WIDTH{out_valid}};

`ifdef GATED_PIPE_OCC_EN
    localparam int OCC_W = occ_width(STAGES);

    logic [OCC_W-1:0] occ_d, occ_q;

    // Counts the valids each stage will hold after this edge, so the register
    // tracks the stage valids exactly.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(!flush && (rdy[i] ? vprev[i] : vld[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`endif

endmodule
